// File: rtl/dma_scheduler_pkg.sv
// Shared constants for the data-memory DMA scheduler: memory geometry, copy
// length, FSM state type and the default copy timeout.
package dma_scheduler_pkg;

   localparam int DATA_ADDR_WIDTH = 8;
   localparam int DATA_WIDTH      = 16;
   localparam int KEY_NUM         = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_COPY,
      ST_RELEASE
   } dma_state_e;

   // Slack of four cycles on top of the nominal copy length.
   function automatic int default_timeout(input int copy_len);
      return copy_len + 4;
   endfunction

endpackage

// File: rtl/dma_scheduler_if.sv
// Frame/CPU/DMA/memory signal bundle of the DMA scheduler.
interface dma_scheduler_if #(
   parameter int ADDR_WIDTH = dma_scheduler_pkg::DATA_ADDR_WIDTH
);
   import dma_scheduler_pkg::*;

   logic                  frame_start;
   logic                  enable;
   logic                  cpu_mem_we;
   logic [ADDR_WIDTH-1:0] cpu_mem_addr;
   logic [DATA_WIDTH-1:0] cpu_mem_din;
   logic                  dma_mem_we;
   logic [ADDR_WIDTH-1:0] dma_mem_addr;
   logic [DATA_WIDTH-1:0] dma_mem_din;
   logic                  dma_copy_start;
   logic                  cpu_stall;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic                  overrun;
   logic                  timeout_err;

   modport slave (
      input  frame_start, enable,
      input  cpu_mem_we, cpu_mem_addr, cpu_mem_din,
      input  dma_mem_we, dma_mem_addr, dma_mem_din,
      output dma_copy_start, cpu_stall,
      output mem_we, mem_addr, mem_din,
      output overrun, timeout_err
   );

   modport master (
      output frame_start, enable,
      output cpu_mem_we, cpu_mem_addr, cpu_mem_din,
      output dma_mem_we, dma_mem_addr, dma_mem_din,
      input  dma_copy_start, cpu_stall,
      input  mem_we, mem_addr, mem_din,
      input  overrun, timeout_err
   );

endinterface

// File: rtl/dma_scheduler.sv
// Frame-boundary DMA scheduler: hands the data-memory write port from the CPU
// to a DMA client for one copy per frame, with overrun and timeout flags.
module dma_scheduler
   import dma_scheduler_pkg::*;
#(
   parameter int ADDR_WIDTH = DATA_ADDR_WIDTH,
   parameter int COPY_LEN   = KEY_NUM,
   parameter int TIMEOUT    = default_timeout(COPY_LEN)
) (
   input  logic           clk,
   input  logic           reset,
   dma_scheduler_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int WW = CW + 1;
   localparam logic [CW-1:0] CYC_MAX   = CW'(TIMEOUT);
   localparam logic [WW-1:0] WORDS_EXP = WW'(COPY_LEN);

   dma_state_e            state;
   dma_state_e            state_nxt;
   logic [CW-1:0]         cyc_cnt;
   logic [WW-1:0]         word_cnt;
   logic                  dma_we_q;
   logic                  timed_out;
   logic                  copy_end;
   logic                  overrun_q;
   logic                  timeout_err_q;
   logic                  mux_we;
   logic [ADDR_WIDTH-1:0] mux_addr;
   logic [DATA_WIDTH-1:0] mux_din;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      timed_out = 1'b0;
      copy_end  = 1'b0;
      case (state)
         ST_IDLE:    if (bus.frame_start && bus.enable) state_nxt = ST_START;
         ST_START:   state_nxt = ST_COPY;
         ST_COPY: begin
            timed_out = (cyc_cnt == CYC_MAX);
            copy_end  = timed_out || (dma_we_q && !bus.dma_mem_we);
            if (copy_end) state_nxt = ST_RELEASE;
         end
         ST_RELEASE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Port select depends on the registered state only; in IDLE the CPU
   // request passes straight through so a write in the frame_start cycle lands.
   always_comb begin
      mux_we   = 1'b0;
      mux_addr = '0;
      mux_din  = '0;
      case (state)
         ST_IDLE: begin
            mux_we   = bus.cpu_mem_we;
            mux_addr = bus.cpu_mem_addr;
            mux_din  = bus.cpu_mem_din;
         end
         ST_COPY: begin
            mux_we   = bus.dma_mem_we;
            mux_addr = bus.dma_mem_addr;
            mux_din  = bus.dma_mem_din;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.dma_copy_start = (state == ST_START);
      bus.cpu_stall      = (state != ST_IDLE);
      bus.mem_we         = mux_we;
      bus.mem_addr       = mux_addr;
      bus.mem_din        = mux_din;
      bus.overrun        = overrun_q;
      bus.timeout_err    = timeout_err_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt       <= '0;
         word_cnt      <= '0;
         dma_we_q      <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         // Only a write seen inside COPY can arm the falling-edge detector.
         dma_we_q <= (state == ST_COPY) && bus.dma_mem_we;
         case (state)
            ST_START: begin
               cyc_cnt  <= '0;
               word_cnt <= '0;
            end
            ST_COPY: begin
               if (cyc_cnt != CYC_MAX) cyc_cnt <= cyc_cnt + 1'b1;
               if (bus.dma_mem_we && word_cnt != '1) word_cnt <= word_cnt + 1'b1;
               if (copy_end && (timed_out || word_cnt != WORDS_EXP)) timeout_err_q <= 1'b1;
            end
            default: ;
         endcase
         if (bus.frame_start && state != ST_IDLE) overrun_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma_scheduler.sv
// Randomized bench for dma_scheduler against a frame-timeline reference model.
module tb_dma_scheduler;

   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int CL  = 4;
   localparam int TMO = 8;

   logic clk;
   logic reset;

   dma_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

   dma_scheduler #(
      .ADDR_WIDTH(AW),
      .COPY_LEN  (CL),
      .TIMEOUT   (TMO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int t = 0;

   // Reference model: an accepted frame at cycle acc occupies cycles
   // acc+1 (start), acc+2..acc+2+e_exit (copy), acc+3+e_exit (release).
   int acc = -1;
   int e_exit = 0;
   int fd = 0;
   int fk = 0;
   bit frm_err = 1'b0;
   bit ovr_exp = 1'b0;
   bit err_exp = 1'b0;
   int nxt_d = 0;
   int nxt_k = CL;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
      end
   endtask

   task automatic cycle(input bit fs, input bit en, input bit rst, input int cpu_addr);
      int rel;
      bit busy;
      bit exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_din;
      @(posedge clk);
      #1;
      t++;
      rel = (acc >= 0) ? t - acc : 0;
      if (acc >= 0 && rel > e_exit + 3) begin
         acc = -1;
         rel = 0;
      end
      busy = (acc >= 0);
      if (busy && rel == e_exit + 3 && frm_err) err_exp = 1'b1;

      reset           = rst;
      bus.frame_start = fs;
      bus.enable      = en;
      if (cpu_addr >= 0) begin
         bus.cpu_mem_we   = 1'b1;
         bus.cpu_mem_addr = AW'(cpu_addr);
      end else begin
         bus.cpu_mem_we   = 1'($urandom_range(0, 1));
         bus.cpu_mem_addr = AW'($urandom);
      end
      bus.cpu_mem_din  = DW'($urandom);
      bus.dma_mem_we   = busy && rel >= 2 + fd && rel < 2 + fd + fk && rel <= 2 + e_exit;
      bus.dma_mem_addr = AW'($urandom);
      bus.dma_mem_din  = DW'($urandom);

      @(negedge clk);
      if (!busy) begin
         exp_we   = bus.cpu_mem_we;
         exp_addr = bus.cpu_mem_addr;
         exp_din  = bus.cpu_mem_din;
      end else if (rel >= 2 && rel <= 2 + e_exit) begin
         exp_we   = bus.dma_mem_we;
         exp_addr = bus.dma_mem_addr;
         exp_din  = bus.dma_mem_din;
      end else begin
         exp_we   = 1'b0;
         exp_addr = '0;
         exp_din  = '0;
      end
      chk("cpu_stall", 32'(bus.cpu_stall), 32'(busy));
      chk("dma_copy_start", 32'(bus.dma_copy_start), 32'(busy && rel == 1));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (exp_we) begin
         chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
         chk("mem_din", 32'(bus.mem_din), 32'(exp_din));
      end
      chk("overrun", 32'(bus.overrun), 32'(ovr_exp));
      chk("timeout_err", 32'(bus.timeout_err), 32'(err_exp));

      if (rst) begin
         acc     = -1;
         ovr_exp = 1'b0;
         err_exp = 1'b0;
      end else if (fs) begin
         if (busy) ovr_exp = 1'b1;
         else if (en) begin
            acc = t;
            fd  = nxt_d;
            fk  = nxt_k;
            // Copy ends on the falling edge of the DMA write burst, else at the timeout.
            e_exit  = (fk > 0 && fd + fk <= TMO) ? fd + fk : TMO;
            frm_err = (e_exit == TMO) || (fk != CL);
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, -1);
   endtask

   initial begin
      reset            = 1'b1;
      bus.frame_start  = 1'b0;
      bus.enable       = 1'b0;
      bus.cpu_mem_we   = 1'b0;
      bus.cpu_mem_addr = '0;
      bus.cpu_mem_din  = '0;
      bus.dma_mem_we   = 1'b0;
      bus.dma_mem_addr = '0;
      bus.dma_mem_din  = '0;
      repeat (3) @(posedge clk);

      idle_cycles(2);

      // Nominal copy with a CPU write to 0x10 in the frame_start cycle.
      nxt_d = 0; nxt_k = CL;
      cycle(1'b1, 1'b1, 1'b0, 'h10);
      idle_cycles(9);

      // enable low: frame_start ignored.
      cycle(1'b1, 1'b0, 1'b0, -1);
      idle_cycles(2);

      // Second frame_start during COPY, and enable dropping mid-copy.
      nxt_d = 1; nxt_k = CL;
      cycle(1'b1, 1'b1, 1'b0, -1);
      cycle(1'b0, 1'b0, 1'b0, -1);
      cycle(1'b0, 1'b0, 1'b0, -1);
      cycle(1'b1, 1'b1, 1'b0, -1);
      idle_cycles(8);

      // DMA never writes: timeout path.
      nxt_d = 0; nxt_k = 0;
      cycle(1'b1, 1'b1, 1'b0, -1);
      idle_cycles(14);

      // Short copy of three words.
      nxt_d = 1; nxt_k = 3;
      cycle(1'b1, 1'b1, 1'b0, -1);
      idle_cycles(8);

      // Reset in the second COPY cycle clears state and sticky flags.
      nxt_d = 0; nxt_k = CL;
      cycle(1'b1, 1'b1, 1'b0, -1);
      cycle(1'b0, 1'b1, 1'b0, -1);
      cycle(1'b0, 1'b1, 1'b0, -1);
      cycle(1'b0, 1'b1, 1'b1, -1);
      idle_cycles(3);

      // Reset takes priority over a same-cycle frame_start.
      cycle(1'b1, 1'b1, 1'b1, -1);
      idle_cycles(2);

      for (int i = 0; i < 2000; i++) begin
         nxt_d = $urandom_range(0, 2);
         nxt_k = ($urandom_range(0, 9) < 6) ? CL : int'($urandom_range(0, TMO + 2));
         cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) < 85),
               1'($urandom_range(0, 99) == 0), -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dma_scheduler.md
DMA_SCHEDULER -- requirements
Module: dma_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default `DATA_ADDR_WIDTH, data memory address width.
REQ-002 Parameter COPY_LEN, default `KEY_NUM, number of words a DMA copy writes.
REQ-003 Parameter TIMEOUT, default COPY_LEN+4, maximum cycles allowed from START to copy end.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_start  input  1  one-cycle pulse requesting a frame-boundary DMA copy.
REQ-007 enable  input  1  when low, frame_start is ignored.
REQ-008 cpu_mem_we / cpu_mem_addr / cpu_mem_din  input  1/ADDR_WIDTH/16  CPU data-memory write request.
REQ-009 dma_mem_we / dma_mem_addr / dma_mem_din  input  1/ADDR_WIDTH/16  DMA client write port.
REQ-010 dma_copy_start  output  1  one-cycle start pulse to the DMA client.
REQ-011 cpu_stall  output  1  high while the CPU does not own the memory port.
REQ-012 mem_we / mem_addr / mem_din  output  1/ADDR_WIDTH/16  muxed data-memory write port.
REQ-013 overrun  output  1  sticky: frame_start arrived while not IDLE.
REQ-014 timeout_err  output  1  sticky: copy did not finish within TIMEOUT cycles.

Function
REQ-015 FSM states SHALL be IDLE, START, COPY, RELEASE, registered.
REQ-016 IDLE: frame_start=1 and enable=1 -> START next cycle; otherwise stay.
REQ-017 START (exactly 1 cycle): dma_copy_start=1, cpu_stall=1, mem_we=0; -> COPY.
REQ-018 COPY: port muxed to dma_* inputs; cpu_stall=1; falling edge of dma_mem_we (high previous cycle, low now) -> RELEASE.
REQ-019 COPY with cycle counter reaching TIMEOUT -> RELEASE, timeout_err set.
REQ-020 RELEASE (1 cycle): cpu_stall=1, mem_we=0; -> IDLE.
REQ-021 In IDLE, port muxed combinationally to cpu_* and cpu_stall=0; a CPU write in the frame_start cycle SHALL complete.
REQ-022 cpu_stall, dma_copy_start, and mux select SHALL be decoded from the registered state only (no combinational path from frame_start).
REQ-023 Cycle counter: clog2(TIMEOUT+1) bits, cleared in START, increments in COPY, saturates at TIMEOUT.
REQ-024 Words written by DMA during COPY SHALL be counted; value != COPY_LEN at RELEASE sets timeout_err.
REQ-025 frame_start in START/COPY/RELEASE SHALL be dropped (no queueing) and set overrun.
REQ-026 enable dropping mid-copy SHALL NOT abort; the copy completes normally.
REQ-027 Sticky flags clear only on reset.
REQ-028 Latency: frame_start at cycle N -> dma_copy_start at N+1, first DMA write earliest N+2, cpu_stall low again two cycles after the dma_mem_we falling edge.

Reset
REQ-029 Reset SHALL force IDLE, counters 0, overrun=0, timeout_err=0, dma_copy_start=0, cpu_stall=0.
REQ-030 Reset during COPY SHALL return to IDLE next cycle with no further mem_we from the DMA mux.
REQ-031 Reset has priority over frame_start in the same cycle.

Structure
REQ-032 State encoding enum and TIMEOUT default SHALL live in the shared constants header next to `KEY_NUM/`KEY_MEM.
REQ-033 Single module; no sub-module; the memory mux is inline logic.

Verification
REQ-034 COPY_LEN=4: frame_start pulse, DMA drives we for 4 cycles -> copy_start 1 cycle later, 4 muxed writes, cpu_stall high 7 cycles total, then IDLE.
REQ-035 CPU write addr 0x10 in the frame_start cycle -> mem_we=1, addr 0x10 that cycle; stall from next cycle.
REQ-036 Second frame_start during COPY -> overrun=1, no second copy_start, flag persists until reset.
REQ-037 DMA never asserts we -> RELEASE after TIMEOUT cycles, timeout_err=1, cpu_stall released.
REQ-038 DMA writes 3 words with COPY_LEN=4 -> timeout_err=1 at RELEASE.
REQ-039 Reset asserted in 2nd COPY cycle -> next cycle IDLE, cpu_stall=0, flags 0, mem_we follows cpu_mem_we.
